// File: rtl/cdc_2phase_rx_fifo_if.sv
// Bundle of the two-phase link (req/data/ack) and the valid/ready stream of cdc_2phase_rx_fifo.
// slave = FIFO side, master = the sender/consumer environment.
interface cdc_2phase_rx_fifo_if #(
   parameter type         T     = logic,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned UW = $clog2(DEPTH + 1);

   logic          async_req_i;
   T              async_data_i;
   logic          async_ack_o;
   T              data_o;
   logic          valid_o;
   logic          ready_i;
   logic [UW-1:0] usage_o;
   logic          err_o;

   modport slave (
      input  async_req_i, async_data_i, ready_i,
      output async_ack_o, data_o, valid_o, usage_o, err_o
   );

   modport master (
      output async_req_i, async_data_i, ready_i,
      input  async_ack_o, data_o, valid_o, usage_o, err_o
   );
endinterface

// File: rtl/cdc_2phase_rx_fifo.sv
// Clocked receiver for a two-phase bundled-data link: synchronizes req, captures into a FIFO,
// acks on capture. Optional sticky protocol error under `CDC_2PHASE_RX_ERR_EN.
module cdc_2phase_rx_fifo #(
   parameter type         T           = logic,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clr_i,
   cdc_2phase_rx_fifo_if.slave bus
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned UW = $clog2(DEPTH + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   ack_q, ack_d;
   logic [PW-1:0]          wptr_q, wptr_d;
   logic [PW-1:0]          rptr_q, rptr_d;
   logic [UW-1:0]          count_q, count_d;
   T                       mem_q [DEPTH];

   logic req_s;
   logic pending;
   logic push;
   logic pop;

   assign req_s   = sync_q[SYNC_STAGES-1];
   assign pending = req_s ^ ack_q;
   // A flush cycle refuses the capture, so the item stays pending and is taken afterwards.
   assign push    = pending && (count_q < UW'(DEPTH)) && !clr_i;
   assign pop     = (count_q != '0) && bus.ready_i;

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], bus.async_req_i};
      ack_d   = ack_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q + UW'(push) - UW'(pop);
      if (push) begin
         ack_d  = ~ack_q;
         wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
         rptr_d = rptr_q + PW'(1);
      end
      // Flush leaves sync chain and ack phase alone to stay in step with the sender.
      if (clr_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q  <= '0;
         ack_q   <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         sync_q  <= sync_d;
         ack_q   <= ack_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q] <= bus.async_data_i;
      end
   end

   assign bus.async_ack_o = ack_q;
   assign bus.data_o      = mem_q[rptr_q];
   assign bus.valid_o     = (count_q != '0);
   assign bus.usage_o     = count_q;

`ifdef CDC_2PHASE_RX_ERR_EN
   logic req_prev_q;
   logic err_q, err_d;

   // A new req edge while the previous phase was still unacknowledged is a double toggle.
   always_comb begin
      err_d = err_q;
      if ((req_s != req_prev_q) && (req_prev_q != ack_q)) begin
         err_d = 1'b1;
      end
      if (clr_i) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         req_prev_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         req_prev_q <= req_s;
         err_q      <= err_d;
      end
   end

   assign bus.err_o = err_q;
`else
   assign bus.err_o = 1'b0;
`endif

endmodule
